// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with one cycle of latency, synchronous flush
// and a saturating stall counter. Define PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_skid_stage #(
  parameter int DW = 64,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] stall_cnt
);

  // state | meaning
  // EMPTY | no entry held, out_valid=0
  // ONE   | main holds the head entry
  // TWO   | main holds the head, skid holds the next entry (skid build only)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CW-1:0] STALL_MAX = '1;

  state_t        state;
  state_t        state_nxt;
  logic          in_fire;
  logic          out_fire;
  logic          main_ld_in;
  logic [DW-1:0] main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // flush wins over any handshake completing in the same cycle
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nxt = ONE;
        end
        ONE: begin
`ifdef PIPE_SKID_EN
          if (in_fire && !out_fire) begin
            state_nxt = TWO;
          end else if (!in_fire && out_fire) begin
            state_nxt = EMPTY;
          end
`else
          if (!in_fire && out_fire) state_nxt = EMPTY;
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (out_fire) state_nxt = ONE;
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
`ifdef PIPE_SKID_EN
    in_ready  = (state != TWO);
`else
    in_ready  = (state == EMPTY) | out_ready;
`endif
  end

  // Without the skid entry, in_fire in ONE implies out_ready, so ONE always refills main.
  assign main_ld_in = !flush && in_fire &&
                      ((state == EMPTY) || ((state == ONE) && out_fire));

`ifdef PIPE_SKID_EN
  logic [DW-1:0] skid_q;
  logic          skid_ld;
  logic          main_ld_skid;

  assign skid_ld      = !flush && (state == ONE) && in_fire && !out_fire;
  assign main_ld_skid = !flush && (state == TWO) && out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (skid_ld) begin
      skid_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (main_ld_in) begin
      main_q <= in_data;
    end else if (main_ld_skid) begin
      main_q <= skid_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (main_ld_in) begin
      main_q <= in_data;
    end
  end
`endif

  assign out_data = main_q;

  // Survives flush on purpose so redirect storms still show up in the stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: vector table plus directed sequences for pipe_skid_stage, with a payload
// scoreboard; adapts its expectations to whether PIPE_SKID_EN is defined.
`timescale 1ns/1ps
module tb_pipe_skid_stage;
  localparam int DW = 64;
  localparam int CW = 8;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb_q[$];

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic          e_ir;
    logic [CW-1:0] e_st;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // One clock: scoreboard the handshakes at mid-cycle, then return just after the next rising edge.
  task automatic tick();
    logic ifire;
    logic ofire;
    @(negedge clk);
    ifire = in_valid & in_ready;
    ofire = out_valid & out_ready;
    if (ofire) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: out_data %0h delivered with nothing expected", out_data);
      end else begin
        chkd("sb_data", out_data, sb_q.pop_front());
      end
    end
    if (flush) sb_q.delete();
    else if (ifire) sb_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkd("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chkd("rst_out_data", out_data, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    do_reset();

    // table: iv, data, out_ready, flush | out_valid, in_ready, stall_cnt sampled before the edge
    vt[0] = '{1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vt[1] = '{1'b1, 64'h2, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vt[2] = '{1'b1, 64'h3, 1'b0, 1'b0, 1'b1, SKID ? 1'b1 : 1'b0, 8'd0};
    vt[3] = '{1'b1, 64'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vt[4] = '{1'b1, 64'h4, 1'b1, 1'b0, 1'b1, SKID ? 1'b0 : 1'b1, 8'd2};
    vt[5] = '{1'b1, 64'h4, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
    vt[6] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
    vt[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    for (int i = 0; i < 8; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy; flush = vt[i].fl;
      #1;
      chk1($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk1($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_ir);
      chkd($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt), 64'(vt[i].e_st));
      tick();
    end
    chkd("vec_drain", 64'(sb_q.size()), 64'd0);

    // streaming 1..8 at full rate
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 64'(k);
      #1;
      if (k > 1) begin
        chk1($sformatf("stream%0d_valid", k), out_valid, 1'b1);
        chkd($sformatf("stream%0d_data", k), out_data, 64'(k - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    chkd("stream_last", out_data, 64'h8);
    tick();
    chk1("stream_empty", out_valid, 1'b0);
    chkd("stream_stall", 64'(stall_cnt), 64'd0);
    chkd("stream_drain", 64'(sb_q.size()), 64'd0);

`ifdef PIPE_SKID_EN
    // backpressure into the skid entry
    do_reset();
    out_ready = 1'b0;
    chk1("bp_ready_a", in_ready, 1'b1);
    push(64'hA);
    chk1("bp_ready_b", in_ready, 1'b1);
    push(64'hB);
    in_data = 64'hC;
    chk1("bp_full", in_ready, 1'b0);
    chkd("bp_head", out_data, 64'hA);
    tick();
    chk1("bp_hold", in_ready, 1'b0);
    chkd("bp_hold_data", out_data, 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk1("bp_recover", in_ready, 1'b1);
    chkd("bp_second", out_data, 64'hB);
    tick();
    chk1("bp_empty", out_valid, 1'b0);
`else
    // in_ready follows out_ready combinationally while holding one entry
    do_reset();
    out_ready = 1'b1;
    push(64'hA);
    in_valid = 1'b0;
    out_ready = 1'b0; #1;
    chk1("comb_ready_lo", in_ready, 1'b0);
    out_ready = 1'b1; #1;
    chk1("comb_ready_hi", in_ready, 1'b1);
    out_ready = 1'b0; #1;
    chk1("comb_ready_lo2", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 64'hB;
    tick();
    chkd("single_hold", out_data, 64'hA);
    tick();
    chkd("single_hold2", out_data, 64'hA);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chkd("single_next", out_data, 64'hB);
    tick();
    chk1("single_empty", out_valid, 1'b0);
`endif

    // flush while full, with a concurrent input
    do_reset();
    out_ready = 1'b0;
    push(64'h11);
    if (SKID) push(64'h22);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h33; out_ready = !SKID;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk1("flush_valid", out_valid, 1'b0);
    chk1("flush_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("flush_quiet%0d", i), out_valid, 1'b0);
    end

    // async reset while stalled, then resume
    out_ready = 1'b0;
    push(64'h44);
    push(64'h55);
    in_valid = 1'b0;
    tick();
    #2;
    do_reset();
    out_ready = 1'b1;
    push(64'h66);
    push(64'h77);
    in_valid = 1'b0;
    chkd("resume_data", out_data, 64'h77);
    tick();
    chkd("resume_drain", 64'(sb_q.size()), 64'd0);

    // stall counter saturation, not cleared by flush
    do_reset();
    out_ready = 1'b0;
    push(64'h5);
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) chkd("stall_254", 64'(stall_cnt), 64'd254);
      if (i == 254) chkd("stall_255", 64'(stall_cnt), 64'd255);
    end
    chkd("stall_sat", 64'(stall_cnt), 64'd255);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("stall_flush_valid", out_valid, 1'b0);
    chkd("stall_after_flush", 64'(stall_cnt), 64'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Valid/ready pipeline stage between two NPC pipeline stages, e.g. IF→ID or ID→EX. It carries a DW-bit payload with one cycle of latency at full throughput. It uses a two-entry skid buffer so that in_ready is registered and the backpressure path is broken, and it supports a synchronous flush for redirects. A saturating stall counter is provided for performance debug.

## Interface
- DW, 64, payload width in bits.
- CW, 8, stall counter width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held entries (branch/exception redirect).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DW  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DW  payload to downstream.
- stall_cnt  output  CW  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Two storage registers:
  - main drives out_data.
  - skid holds the overflow entry.
- State machine (occupancy), with PIPE_SKID_EN defined:
  - EMPTY: in_fire → ONE, main←in_data.
  - ONE: in_fire & out_fire → ONE, main←in_data.
  - ONE: in_fire & !out_fire → TWO, skid←in_data.
  - ONE: !in_fire & out_fire → EMPTY.
  - ONE: otherwise hold.
  - TWO: out_fire → ONE, main←skid.
  - TWO: otherwise hold.
- Outputs decoded from state registers only:
  - out_valid = (state≠EMPTY).
  - in_ready = (state≠TWO).
- Order is strictly FIFO: the entry in main always leaves before the entry in skid.
- flush has highest priority:
  - Next state is EMPTY regardless of in_fire or out_fire in the same cycle.
  - A payload accepted in the flush cycle is dropped; its handshake still counts as completed upstream.
  - A payload on out_data in the flush cycle counts as consumed if out_ready=1, and is discarded otherwise.
- Data registers are written only on the transitions listed above. Their contents in EMPTY are don't-care, but must not be X after reset.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready, saturating at 2^CW−1.
  - Never wraps.
  - Not cleared by flush; cleared only by reset.
- Downstream obligations:
  - Once out_valid=1, out_valid and out_data stay stable until out_fire or flush.
  - Upstream holds in_valid/in_data until in_fire; the stage does not rely on this for correctness.

## Timing
- Reset (async assert, sync-release assumed by the system) forces:
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data=0, skid=0, stall_cnt=0.
- Latency: in_fire at cycle N → out_valid=1 with that payload at cycle N+1.
- Throughput: one payload per cycle while out_ready=1, with no bubbles.
- With PIPE_SKID_EN, in_ready has no combinational dependence on out_ready, in_valid or flush.
- After out_ready deasserts, at most one further payload is accepted (into skid), then in_ready=0 from the next cycle.
- Recovery from TWO: out_fire at cycle N → in_ready=1 at cycle N+1.
- flush at cycle N → out_valid=0 and in_ready=1 at cycle N+1.
- Reset asserted mid-transfer: all entries are lost immediately and the outputs take their reset values asynchronously.

## Configuration
- Macro PIPE_SKID_EN.
- Defined: two-entry skid behaviour as above. in_ready is registered.
- Undefined:
  - skid register and TWO state are removed; the stage is a single register.
  - in_ready = !out_valid | out_ready, a combinational path from out_ready.
  - Transitions: EMPTY/ONE as above, except ONE with in_fire & !out_fire cannot occur.
  - Latency, throughput, flush, reset and stall_cnt behaviour are unchanged.

## Test plan
- Streaming, DW=64, out_ready=1: push 0x1..0x8 on consecutive cycles → out_data 0x1..0x8 on cycles N+1..N+8, out_valid continuous, stall_cnt=0.
- Backpressure with skid: out_ready=0, push A=0xA, B=0xB → in_ready=0 after B is accepted, out_data=0xA held. Raise out_ready → 0xA then 0xB delivered in order, in_ready=1 one cycle after 0xA leaves.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed payloads and the concurrent input never appear on out_data.
- Async reset while in TWO, out_ready=0 → out_valid=0, in_ready=1, stall_cnt=0 immediately, without waiting for a clock edge. Stage resumes correctly after release.
- Stall saturation, CW=8: hold out_valid=1 with out_ready=0 for 300 cycles → stall_cnt stops at 255. A following flush leaves stall_cnt at 255.
- Build without PIPE_SKID_EN, in ONE: toggle out_ready → in_ready follows out_ready in the same cycle. No payload is ever held in a second entry.
